// File: rtl/ovc_txs_pkg.sv
// Shared definitions for the PCIe TXS burst writer.
// Holds the default TXS bus geometry and the burst FSM state encoding.
package ovc_txs_pkg;

  localparam int TXS_ADDR_W     = 22;
  localparam int TXS_DATA_W     = 128;
  localparam int TXS_BC_W       = 6;
  localparam int BYTES_PER_BEAT = TXS_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    NEXT  = 2'd2
  } state_t;

endpackage

// File: rtl/pcie_txs_burst_writer.sv
// pcie_txs_burst_writer
// Avalon-MM burst write master feeding the PCIe TXS slave. Moves a stream of
// DATA_W-bit beats into a host-memory ring as fixed BURST_LEN-beat bursts at
// consecutive addresses, wrapping to the ring base after cfg_num_bursts bursts
// and pulsing irq once per completed ring pass.
//
// Ports:
//   clk125, rst          clock, synchronous active-high reset
//   enable               start/continue issuing bursts (checked between bursts)
//   cfg_base             ring base byte address (low burst-size bits ignored)
//   cfg_num_bursts       bursts per ring pass (0 behaves as 1)
//   in_data/in_valid/in_ready   input stream
//   txs_address, txs_burstcount, txs_write, txs_writedata, txs_waitrequest
//                        Avalon-MM burst master to the TXS slave
//   irq                  one-cycle pulse per completed ring pass
//   pass_count           completed ring passes, wraps modulo 2^CNT_W
//   busy                 high while a burst is in progress
//   state_dbg            current FSM state (IDLE/BURST/NEXT encoding)
//
// Handshake: a stream beat moves when in_valid & in_ready at a rising edge;
// the same edge is an Avalon accept (txs_write & ~txs_waitrequest), because in
// BURST txs_write follows in_valid and in_ready is ~txs_waitrequest. Outside
// BURST both txs_write and in_ready are 0.
module pcie_txs_burst_writer
  import ovc_txs_pkg::*;
#(
  parameter int ADDR_W    = TXS_ADDR_W,
  parameter int DATA_W    = TXS_DATA_W,
  parameter int BURST_LEN = 8,
  parameter int BC_W      = TXS_BC_W,
  parameter int CNT_W     = 16
) (
  input  logic              clk125,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [CNT_W-1:0]  cfg_num_bursts,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] txs_address,
  output logic [BC_W-1:0]   txs_burstcount,
  output logic              txs_write,
  output logic [DATA_W-1:0] txs_writedata,
  input  logic              txs_waitrequest,
  output logic              irq,
  output logic [CNT_W-1:0]  pass_count,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int BURST_BYTES = BURST_LEN * DATA_W / 8;
  // floor(log2(BURST_BYTES)): number of low base-address bits forced to 0
  localparam int ALIGN_W     = $clog2(BURST_BYTES + 1) - 1;
  localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_W) - 64'd1);
  localparam logic [ADDR_W-1:0] ADDR_INC = ADDR_W'(BURST_BYTES);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]    burst_idx;
  logic [ADDR_W-1:0]   addr;
  // Set when the next exit from IDLE must (re)load the ring base:
  // after reset, or after a wrap that dropped into IDLE.
  logic                reload;

  logic [ADDR_W-1:0]   base_aligned;
  logic [CNT_W-1:0]    last_idx;
  logic                wrap;
  logic                accept;
  logic                last_beat;
  logic                go;

  assign base_aligned = cfg_base & ~LOW_MASK;
  assign last_idx     = (cfg_num_bursts == '0) ? '0 : cfg_num_bursts - 1'b1;
  // >= so that shrinking cfg_num_bursts mid-pass wraps at the next NEXT
  assign wrap         = (burst_idx >= last_idx);
  assign accept       = (state == BURST) && in_valid && !txs_waitrequest;
  assign last_beat    = (beat_cnt == LAST_BEAT);
  assign go           = enable && in_valid;

  always_comb begin
    state_next = state;
    txs_write  = 1'b0;
    in_ready   = 1'b0;
    irq        = 1'b0;
    case (state)
      IDLE: begin
        if (go) state_next = BURST;
      end
      BURST: begin
        txs_write = in_valid;
        in_ready  = !txs_waitrequest;
        if (accept && last_beat) state_next = NEXT;
      end
      NEXT: begin
        irq        = wrap;
        state_next = go ? BURST : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk125) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      burst_idx  <= '0;
      addr       <= '0;
      pass_count <= '0;
      reload     <= 1'b1;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (go && reload) begin
            addr   <= base_aligned;
            reload <= 1'b0;
          end
        end
        BURST: begin
          if (accept) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
        NEXT: begin
          if (wrap) begin
            burst_idx  <= '0;
            addr       <= base_aligned;
            pass_count <= pass_count + 1'b1;
            reload     <= !go;
          end else begin
            burst_idx <= burst_idx + 1'b1;
            addr      <= addr + ADDR_INC;
          end
        end
        default: ;
      endcase
    end
  end

  assign txs_address    = addr;
  assign txs_burstcount = BC_W'(BURST_LEN);
  assign txs_writedata  = in_data;
  assign busy           = (state == BURST);
  assign state_dbg      = state;

endmodule

// File: doc/pcie_txs_burst_writer.md
Name: pcie_txs_burst_writer

Overview:
Avalon-MM burst write master that drives the PCIe hard-IP TXS slave port and moves a 128-bit data stream into a host-memory ring buffer. It sits between the camera/IMU stream sources in top and the platform TXS port (txs_write/txs_address/txs_burstcount/txs_writedata/txs_waitrequest). It is the initiator for the TXS slave, which today is tied off. It issues fixed-length bursts at consecutive addresses, wraps at the ring end, and raises a one-cycle interrupt pulse for each completed ring pass.

Parameters:
ADDR_W, 22, TXS byte-address width
DATA_W, 128, TXS data width (bits)
BURST_LEN, 8, beats per burst (1..32)
BC_W, 6, txs_burstcount width
CNT_W, 16, width of ring-length and pass counters

Ports:
clk125  in  1  PCIe application clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  level; 1 = start or continue issuing bursts
cfg_base  in  ADDR_W  ring base byte address; low log2(BURST_LEN*DATA_W/8) bits ignored (treated as 0)
cfg_num_bursts  in  CNT_W  bursts per ring pass; 0 treated as 1
in_data  in  DATA_W  stream data
in_valid  in  1  stream data valid
in_ready  out  1  stream beat consumed this cycle when in_valid & in_ready
txs_address  out  ADDR_W  burst start byte address
txs_burstcount  out  BC_W  constant BURST_LEN
txs_write  out  1  Avalon write
txs_writedata  out  DATA_W  Avalon write data
txs_waitrequest  in  1  Avalon slave stall
irq  out  1  one-cycle pulse at the end of each ring pass
pass_count  out  CNT_W  completed ring passes; wraps modulo 2^CNT_W
busy  out  1  1 while a burst is in progress

Behaviour:
- Reset values: txs_write=0, in_ready=0, txs_address=cfg_base-aligned value sampled after reset (register = 0 at reset), irq=0, pass_count=0, busy=0, internal beat_cnt=0, burst_idx=0, state=IDLE.
- States:
  - IDLE: if enable & in_valid, go to BURST. If leaving IDLE after reset or after a wrap, txs_address is loaded with aligned cfg_base.
  - BURST: txs_write = in_valid; txs_writedata = in_data (combinational pass-through); in_ready = ~txs_waitrequest.
    - A beat is accepted when txs_write & ~txs_waitrequest.
    - txs_address and txs_burstcount are held stable for the whole burst.
    - The source may drop in_valid mid-burst; txs_write then deasserts, which is legal for an Avalon burst.
    - beat_cnt increments per accepted beat. On acceptance of beat BURST_LEN-1, go to NEXT.
  - NEXT (1 cycle): txs_write=0, in_ready=0.
    - If burst_idx == max(cfg_num_bursts,1)-1: burst_idx<=0, txs_address<=aligned cfg_base, pass_count++, irq=1 this cycle.
    - Else: burst_idx++, txs_address += BURST_LEN*DATA_W/8 (128 by default). Address arithmetic is modulo 2^ADDR_W.
    - Then go to BURST if enable & in_valid, else IDLE.
- busy = (state==BURST).
- Latency: first beat can be accepted on the cycle after in_valid is seen in IDLE. Minimum inter-burst gap is 1 cycle (NEXT).
- Deasserting enable mid-burst has no effect until the burst completes: a started burst always finishes all BURST_LEN beats. Afterwards the block waits in IDLE; the pointer is kept, not reset to base.
- cfg_base and cfg_num_bursts are sampled only on wrap, on reset, and at NEXT. Changing them mid-pass takes effect at the next wrap, except that a new cfg_num_bursts below the current burst_idx+1 causes a wrap at the next NEXT (compare uses >=).
- Reset mid-burst aborts immediately. The host-side partial burst is accepted as lost; no recovery.
- Never present a new burst while waitrequest is high and write is asserted with a changed address.

Decomposition:
- Package ovc_txs_pkg holds:
  - localparams TXS_ADDR_W=22, TXS_DATA_W=128, TXS_BC_W=6
  - BYTES_PER_BEAT = TXS_DATA_W/8
  - state enum {IDLE, BURST, NEXT}
- No sub-module needed. The beat counter, burst index, and address register are inline.

Test Plan:
- Continuous valid, waitrequest=0, cfg_base=0x1000, cfg_num_bursts=2, enable=1 -> bursts at 0x1000 then 0x1080, 8 beats each, 1-cycle gap between them; irq pulse after the 16th beat; pass_count=1; third burst at 0x1000.
- waitrequest high on beats 0 and 5 for 3 cycles each -> write held with the same data, address stays 0x1000, beat counter does not advance; exactly 8 beats accepted; in_ready=0 during the stalls.
- in_valid drops for 4 cycles after beat 3 -> txs_write=0 in those cycles, burst resumes at beat 4, address unchanged, total 8 beats.
- enable deasserted at beat 2 -> burst completes 8 beats, then IDLE with busy=0. Re-enabling resumes at address +0x80, not at base.
- cfg_num_bursts=0, cfg_base=0x3FFF80 -> every burst at 0x3FFF80, irq after each burst; pass_count increments per burst and wraps 0xFFFF->0.
- rst asserted at beat 4 -> next cycle txs_write=0, in_ready=0, busy=0, pass_count=0. The next burst starts at aligned cfg_base.
